// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM states, register
// map offsets and CTRL/STATUS bit positions.
package matmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam int CTRL_ADDR   = 0;
    localparam int STATUS_ADDR = 1;
    localparam int A_BASE      = 2;

    // B and C windows move with the matrix size.
    function automatic int b_base(input int max_dim);
        return A_BASE + max_dim;
    endfunction

    function automatic int c_base(input int max_dim);
        return A_BASE + 2 * max_dim;
    endfunction

    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_N     = 2;
    localparam int CTRL_K     = 4;
    localparam int CTRL_M     = 6;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_ERR_BUSY = 2;
    localparam int ST_ERR_TO   = 3;
    localparam int ST_FLAGS    = 4;

endpackage

// File: rtl/matmul_ctrl_regs.sv
// Host-visible operand/result buffers and the registered read mux.
// A rows and B columns map one bus word each; C is one word per element.
module matmul_ctrl_regs
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 5,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int NE        = MAX_DIM * MAX_DIM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [BUS_WIDTH-1:0]          wr_data,
    input  logic                          wr_allow,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [BUS_WIDTH-1:0]          ctrl_word,
    input  logic [BUS_WIDTH-1:0]          status_word,
    input  logic                          capture,
    input  logic [NE*BUS_WIDTH-1:0]       res,
    output logic [BUS_WIDTH-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [NE*DATA_WIDTH-1:0]      a_matrix,
    output logic [NE*DATA_WIDTH-1:0]      b_matrix,
    output logic [NE*BUS_WIDTH-1:0]       c_matrix
);
    localparam int B_BASE = b_base(MAX_DIM);
    localparam int C_BASE = c_base(MAX_DIM);

    logic [MAX_DIM-1:0][BUS_WIDTH-1:0] a_rows;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0] b_cols;
    logic [NE-1:0][BUS_WIDTH-1:0]      c_elems;
    logic [BUS_WIDTH-1:0]              rd_word;

    // A row-major and B column-major words are already in datapath order.
    assign a_matrix = a_rows;
    assign b_matrix = b_cols;
    assign c_matrix = c_elems;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rows  <= '0;
            b_cols  <= '0;
            c_elems <= '0;
        end else begin
            if (wr_en && wr_allow) begin
                for (int i = 0; i < MAX_DIM; i++) begin
                    if (wr_addr == ADDR_WIDTH'(A_BASE + i)) a_rows[i] <= wr_data;
                    if (wr_addr == ADDR_WIDTH'(B_BASE + i)) b_cols[i] <= wr_data;
                end
            end
            if (capture) c_elems <= res;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_addr == ADDR_WIDTH'(CTRL_ADDR))   rd_word = ctrl_word;
        if (rd_addr == ADDR_WIDTH'(STATUS_ADDR)) rd_word = status_word;
        for (int i = 0; i < MAX_DIM; i++) begin
            if (rd_addr == ADDR_WIDTH'(A_BASE + i)) rd_word = a_rows[i];
            if (rd_addr == ADDR_WIDTH'(B_BASE + i)) rd_word = b_cols[i];
        end
        for (int i = 0; i < NE; i++) begin
            if (rd_addr == ADDR_WIDTH'(C_BASE + i)) rd_word = c_elems[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// Register-mapped sequencer for the systolic matmul datapath: host writes
// operands and CTRL, the FSM holds start until finish or watchdog abort.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 32,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int NE        = MAX_DIM * MAX_DIM
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
    input  logic [BUS_WIDTH-1:0]          wr_data_i,
    input  logic                          rd_en_i,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
    output logic [BUS_WIDTH-1:0]          rd_data_o,
    output logic                          rd_valid_o,
    output logic                          irq_o,
    output logic                          mm_start_o,
    output logic                          mm_mode_o,
    output logic [1:0]                    mm_n_dim_o,
    output logic [1:0]                    mm_k_dim_o,
    output logic [1:0]                    mm_m_dim_o,
    output logic [NE*DATA_WIDTH-1:0]      mm_a_matrix_o,
    output logic [NE*DATA_WIDTH-1:0]      mm_b_matrix_o,
    output logic [NE*BUS_WIDTH-1:0]       mm_c_matrix_o,
    input  logic [NE*BUS_WIDTH-1:0]       mm_res_i,
    input  logic [NE-1:0]                 mm_flags_i,
    input  logic                          mm_finish_i
);
    localparam int WD_W = $clog2(TIMEOUT + 2);

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd;
    logic            mode;
    logic [1:0]      n_dim, k_dim, m_dim;
    logic            done, err_busy, err_timeout;
    logic [NE-1:0]   flags;
    logic            busy, ctrl_wr, start_req, start_ok, capture, timed_out;
    logic [BUS_WIDTH-1:0] ctrl_word, status_word;

    assign busy      = (state != S_IDLE);
    assign ctrl_wr   = wr_en_i && (wr_addr_i == ADDR_WIDTH'(CTRL_ADDR));
    assign start_req = ctrl_wr && wr_data_i[CTRL_START];
    assign start_ok  = start_req && !busy;
    assign capture   = (state == S_RUN) && mm_finish_i;
    // Abort lands on the edge TIMEOUT+1 cycles after start rises.
    assign timed_out = (state == S_RUN) && !mm_finish_i && (wd == WD_W'(TIMEOUT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mm_start_o = 1'b0;
        irq_o      = 1'b0;
        unique case (state)
            S_IDLE: if (start_ok) state_nxt = S_ARM;
            S_ARM:  state_nxt = S_RUN;
            S_RUN: begin
                mm_start_o = 1'b1;
                if (capture || timed_out) state_nxt = S_DONE;
            end
            S_DONE: begin
                irq_o     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd          <= '0;
            mode        <= 1'b0;
            n_dim       <= '0;
            k_dim       <= '0;
            m_dim       <= '0;
            done        <= 1'b0;
            err_busy    <= 1'b0;
            err_timeout <= 1'b0;
            flags       <= '0;
        end else begin
            if (state == S_ARM)      wd <= '0;
            else if (state == S_RUN) wd <= wd + 1'b1;
            if (ctrl_wr && !busy) begin
                mode  <= wr_data_i[CTRL_MODE];
                n_dim <= wr_data_i[CTRL_N +: 2];
                k_dim <= wr_data_i[CTRL_K +: 2];
                m_dim <= wr_data_i[CTRL_M +: 2];
            end
            if (start_ok) begin
                done        <= 1'b0;
                err_busy    <= 1'b0;
                err_timeout <= 1'b0;
                flags       <= '0;
            end else if (start_req) begin
                err_busy <= 1'b1;
            end
            if (capture)          flags       <= mm_flags_i;
            if (timed_out)        err_timeout <= 1'b1;
            if (state == S_DONE)  done        <= 1'b1;
        end
    end

    always_comb begin
        ctrl_word                  = '0;
        ctrl_word[CTRL_MODE]       = mode;
        ctrl_word[CTRL_N +: 2]     = n_dim;
        ctrl_word[CTRL_K +: 2]     = k_dim;
        ctrl_word[CTRL_M +: 2]     = m_dim;
        status_word                = '0;
        status_word[ST_BUSY]       = busy;
        status_word[ST_DONE]       = done;
        status_word[ST_ERR_BUSY]   = err_busy;
        status_word[ST_ERR_TO]     = err_timeout;
        status_word[ST_FLAGS +: NE] = flags;
    end

    assign mm_mode_o  = mode;
    assign mm_n_dim_o = n_dim;
    assign mm_k_dim_o = k_dim;
    assign mm_m_dim_o = m_dim;

    matmul_ctrl_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regs (
        .clk         (clk_i),
        .rst         (rst_i),
        .wr_en       (wr_en_i),
        .wr_addr     (wr_addr_i),
        .wr_data     (wr_data_i),
        .wr_allow    (!busy),
        .rd_en       (rd_en_i),
        .rd_addr     (rd_addr_i),
        .ctrl_word   (ctrl_word),
        .status_word (status_word),
        .capture     (capture),
        .res         (mm_res_i),
        .rd_data     (rd_data_o),
        .rd_valid    (rd_valid_o),
        .a_matrix    (mm_a_matrix_o),
        .b_matrix    (mm_b_matrix_o),
        .c_matrix    (mm_c_matrix_o)
    );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: a datapath stub answers runs, and a matrix-level
// model of the register map predicts every readback.
module tb_matmul_ctrl;
    localparam int DW = 8, BW = 16, AW = 5, TO = 32;
    localparam int MD = BW / DW, NE = MD * MD;
    localparam int AB = 2, BB = 2 + MD, CB = 2 + 2 * MD;

    logic clk = 1'b0, rst = 1'b1;
    logic wr_en = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [BW-1:0] wr_data = '0, rd_data;
    logic rd_valid, irq, mm_start, mm_mode;
    logic [1:0] mm_n, mm_k, mm_m;
    logic [NE*DW-1:0] mm_a, mm_b;
    logic [NE*BW-1:0] mm_c;
    logic [NE*BW-1:0] mm_res = '0;
    logic [NE-1:0] mm_flags = '0;
    logic mm_finish = 1'b0;

    int total = 0, bad = 0;

    matmul_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .irq_o(irq), .mm_start_o(mm_start), .mm_mode_o(mm_mode), .mm_n_dim_o(mm_n),
        .mm_k_dim_o(mm_k), .mm_m_dim_o(mm_m), .mm_a_matrix_o(mm_a), .mm_b_matrix_o(mm_b),
        .mm_c_matrix_o(mm_c), .mm_res_i(mm_res), .mm_flags_i(mm_flags), .mm_finish_i(mm_finish)
    );

    always #5 clk = ~clk;

    // Datapath stub: signed multiply(-accumulate), finish after stub_lat start cycles.
    int stub_lat = 3;
    bit stub_hang = 1'b0;
    int stub_cnt = 0;
    always @(negedge clk) begin
        if (mm_start) stub_cnt++; else stub_cnt = 0;
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                int s;
                s = mm_mode ? int'($signed(mm_c[(r*MD+c)*BW +: BW])) : 0;
                for (int k = 0; k < MD; k++)
                    s += int'($signed(mm_a[(r*MD+k)*DW +: DW])) * int'($signed(mm_b[(c*MD+k)*DW +: DW]));
                mm_res[(r*MD+c)*BW +: BW] = s[BW-1:0];
                mm_flags[r*MD+c] = (s > 32767) || (s < -32768);
            end
        end
        mm_finish = mm_start && !stub_hang && (stub_cnt == stub_lat);
    end

    // Reference model: matrices as arrays, status as plain bits.
    logic [7:0]  ma [MD][MD];
    logic [7:0]  mb [MD][MD];
    logic [15:0] mc [NE];
    logic [NE-1:0] mflags;
    bit mdone, merrb, merrt, mmode;
    logic [5:0] mdims;

    function automatic void model_clear();
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin ma[i][j] = '0; mb[i][j] = '0; end
        for (int i = 0; i < NE; i++) mc[i] = '0;
        mflags = '0; mdone = 0; merrb = 0; merrt = 0; mmode = 0; mdims = '0;
    endfunction

    function automatic void model_mult(input bit acc);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                int s;
                s = acc ? int'($signed(mc[r*MD+c])) : 0;
                for (int k = 0; k < MD; k++)
                    s += int'($signed(ma[r][k])) * int'($signed(mb[c][k]));
                mflags[r*MD+c] = (s > 32767) || (s < -32768);
                mc[r*MD+c] = s[15:0];
            end
    endfunction

    function automatic logic [15:0] word_of(input bit is_b, input int idx);
        logic [15:0] w;
        for (int k = 0; k < MD; k++) w[k*DW +: DW] = is_b ? mb[idx][k] : ma[idx][k];
        return w;
    endfunction

    function automatic logic [15:0] exp_status(input bit busy);
        return 16'(busy) | (16'(mdone) << 1) | (16'(merrb) << 2) | (16'(merrt) << 3) | (16'(mflags) << 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int addr, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input int addr, input logic [15:0] exp, input string tag);
        rd_en = 1'b1; rd_addr = AW'(addr);
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 1);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic load_ops();
        for (int i = 0; i < MD; i++) wr(AB + i, word_of(0, i));
        for (int i = 0; i < MD; i++) wr(BB + i, word_of(1, i));
    endtask

    task automatic check_all();
        rd_chk(0, {8'h0, mdims, mmode, 1'b0}, "ctrl");
        rd_chk(1, exp_status(0), "status");
        for (int i = 0; i < MD; i++) rd_chk(AB + i, word_of(0, i), "a_row");
        for (int i = 0; i < MD; i++) rd_chk(BB + i, word_of(1, i), "b_col");
        for (int i = 0; i < NE; i++) rd_chk(CB + i, mc[i], "c_elem");
        rd_chk(CB + NE, 16'h0, "unmapped");
        chk("dims_out", 32'({mm_m, mm_k, mm_n}), 32'(mdims));
    endtask

    // One complete run; window covers the watchdog abort with margin.
    task automatic run(input logic [7:0] ctrl, input bit hang, input int lat);
        int irqs, first;
        stub_hang = hang; stub_lat = lat;
        wr(0, {8'h0, ctrl});
        chk("arm_no_start", 32'(mm_start), 0);
        tick();
        chk("run_start", 32'(mm_start), 1);
        irqs = 0; first = -1;
        for (int i = 1; i <= TO + 8; i++) begin
            tick();
            if (irq) begin irqs++; if (first < 0) first = i; end
        end
        chk("irq_count", 32'(irqs), 1);
        if (hang) chk("timeout_lat", 32'(first), TO + 1);
        else      chk("finish_lat", 32'(first), 32'(lat));
        mmode = ctrl[1]; mdims = ctrl[7:2]; merrb = 0; mdone = 1;
        if (hang) begin merrt = 1; mflags = '0; end
        else begin merrt = 0; model_mult(mmode); end
        stub_hang = 1'b0;
    endtask

    initial begin
        int irqs;
        model_clear();
        tick(); tick();
        rst = 1'b0;
        chk("rst_start", 32'(mm_start), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rdv", 32'(rd_valid), 0);
        chk("rst_c", 32'(mm_c == '0), 1);
        check_all();

        // Basic 2x2 then accumulate.
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 7; mb[1][0] = 6; mb[1][1] = 8;
        load_ops();
        run(8'h55, 0, 3);
        check_all();
        chk("basic_c11", 32'(mc[3]), 50);
        run(8'h57, 0, 1);
        check_all();
        chk("acc_c11", 32'(mc[3]), 100);

        // RO writes ignored; CTRL write without start only updates fields.
        wr(1, 16'hFFFF);
        wr(CB, 16'h1234);
        wr(0, 16'h00A2);
        mmode = 1; mdims = 6'h28;
        chk("no_start_idle", 32'(mm_start), 0);
        check_all();

        // Overflow: second run accumulates past the signed range.
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin ma[i][j] = 8'd127; mb[i][j] = 8'd127; end
        load_ops();
        run(8'h55, 0, 2);
        check_all();
        run(8'h57, 0, 2);
        check_all();
        chk("ovf_flags", 32'(mflags), 32'((1 << NE) - 1));

        // Busy protection.
        stub_lat = 10;
        wr(0, 16'h0055);
        mdone = 0; merrt = 0; mflags = '0; merrb = 0; mmode = 0; mdims = 6'h15;
        tick();
        wr(0, 16'h0057);
        wr(AB, 16'hFFFF);
        merrb = 1;
        rd_chk(1, exp_status(1), "busy_status");
        rd_chk(CB, mc[0], "busy_c_old");
        irqs = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (irq) irqs++; end
        chk("busy_irq", 32'(irqs), 1);
        model_mult(0); mdone = 1;
        check_all();

        // Timeout: C untouched.
        run(8'h55, 1, 1);
        check_all();

        // Same-cycle read and write of A row 0 returns the old value.
        rd_en = 1'b1; rd_addr = AW'(AB); wr_en = 1'b1; wr_addr = AW'(AB); wr_data = 16'h0302;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("rw_old", 32'(rd_data), 32'(word_of(0, 0)));
        ma[0][0] = 8'h02; ma[0][1] = 8'h03;
        rd_chk(AB, word_of(0, 0), "rw_new");

        // Reset mid-run.
        stub_lat = 10;
        wr(0, 16'h0055);
        tick(); tick();
        chk("pre_rst_start", 32'(mm_start), 1);
        #2 rst = 1'b1;
        #1 chk("rst_drop_start", 32'(mm_start), 0);
        chk("rst_drop_irq", 32'(irq), 0);
        rst = 1'b0;
        model_clear();
        irqs = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (irq) irqs++; end
        chk("rst_no_irq", 32'(irqs), 0);
        check_all();
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 7; mb[1][0] = 6; mb[1][1] = 8;
        load_ops();
        run(8'h55, 0, 4);
        check_all();

        // Randomized runs.
        for (int it = 0; it < 6; it++) begin
            logic [7:0] ctrl;
            for (int i = 0; i < MD; i++)
                for (int j = 0; j < MD; j++) begin
                    ma[i][j] = 8'($urandom_range(0, 255));
                    mb[i][j] = 8'($urandom_range(0, 255));
                end
            load_ops();
            ctrl = {6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b1};
            run(ctrl, 0, int'($urandom_range(1, 6)));
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
